// File: rtl/muldiv_pkg.sv
// Shared types and opcode decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic op1_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op2_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mul_radix_step.sv
// One multiply iteration: retires MUL_UNROLL multiplier bits into a right-shifting
// {carry, high, low} accumulator so the full product lands in acc after XLEN bits.
module mul_radix_step #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_UNROLL = 2
) (
  input  logic [2*XLEN-1:0]     acc_in,
  input  logic [XLEN-1:0]       multiplicand,
  input  logic [MUL_UNROLL-1:0] mbits,
  output logic [2*XLEN-1:0]     acc_out
);

  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     sum;

  always_comb begin
    acc = acc_in;
    sum = '0;
    for (int i = 0; i < int'(MUL_UNROLL); i++) begin
      sum = {1'b0, acc[2*XLEN-1:XLEN]} + (mbits[i] ? {1'b0, multiplicand} : {(XLEN+1){1'b0}});
      acc = {sum, acc[XLEN-1:1]};
    end
    acc_out = acc;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage: shift-add multiply,
// restoring divide, divide fast paths, pipeline stall and kill.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_UNROLL = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            kill,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW        = $clog2(XLEN + 1);
  localparam int unsigned MUL_STEPS = XLEN / MUL_UNROLL;
  localparam logic [XLEN-1:0] SMIN  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state;
  muldiv_op_e        op_q;
  logic              neg_q;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   mplier;

  muldiv_op_e        op_in;
  logic              a_neg, b_neg, neg_in;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, fast;
  logic [XLEN-1:0]   fast_val;

  logic [2*XLEN-1:0] mul_acc, div_acc, next_acc, prod;
  logic [XLEN:0]     trial, diff;
  logic [XLEN-1:0]   quo, rem, final_res;

  assign stall = ((state == IDLE) && start && !kill) || (state == BUSY);

  // Request decode: magnitudes, result sign and the divide short-cuts.
  always_comb begin
    op_in    = muldiv_op_e'(op);
    a_neg    = op1_signed(op_in) & operand1[XLEN-1];
    b_neg    = op2_signed(op_in) & operand2[XLEN-1];
    a_mag    = a_neg ? -operand1 : operand1;
    b_mag    = b_neg ? -operand2 : operand2;
    neg_in   = (is_div(op_in) && op_in[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = (operand2 == '0);
    div_ovf  = op1_signed(op_in) && (operand1 == SMIN) && (&operand2);
    fast     = is_div(op_in) && (div_zero || div_ovf);
    if (div_zero) fast_val = op_in[1] ? operand1 : '1;
    else          fast_val = op_in[1] ? '0 : SMIN;
  end

  mul_radix_step #(
    .XLEN      (XLEN),
    .MUL_UNROLL(MUL_UNROLL)
  ) u_step (
    .acc_in      (acc),
    .multiplicand(mcand),
    .mbits       (mplier[MUL_UNROLL-1:0]),
    .acc_out     (mul_acc)
  );

  // Restoring divide step on acc = {remainder, dividend/quotient}, then sign fix-up.
  always_comb begin
    trial    = acc[2*XLEN-1:XLEN-1];
    diff     = trial - {1'b0, mcand};
    div_acc  = diff[XLEN] ? {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    next_acc = is_div(op_q) ? div_acc : mul_acc;
    prod     = neg_q ? -next_acc : next_acc;
    quo      = neg_q ? -next_acc[XLEN-1:0] : next_acc[XLEN-1:0];
    rem      = neg_q ? -next_acc[2*XLEN-1:XLEN] : next_acc[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                      final_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             final_res = quo;
      default:                     final_res = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_MUL;
      neg_q      <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      resp_valid <= 1'b0;
      result     <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !kill) begin
            if (fast) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              result     <= fast_val;
            end else begin
              state  <= BUSY;
              op_q   <= op_in;
              neg_q  <= neg_in;
              cnt    <= is_div(op_in) ? CW'(XLEN) : CW'(MUL_STEPS);
              acc    <= is_div(op_in) ? {{XLEN{1'b0}}, a_mag} : '0;
              mcand  <= is_div(op_in) ? b_mag : a_mag;
              mplier <= b_mag;
            end
          end
        end
        BUSY: begin
          if (kill) begin
            state <= IDLE;
          end else begin
            acc    <= next_acc;
            mplier <= mplier >> MUL_UNROLL;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              result     <= final_res;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: three muldiv_unit instances (unroll 2, 1, 4) run every request
// side by side against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        kill;
  logic [2:0]  stall_w;
  logic [2:0]  rv_w;
  logic [31:0] res_w [3];

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [31:0] prev_res [3];
  int          unroll   [3];

  muldiv_unit #(.XLEN(32), .MUL_UNROLL(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .op(op), .operand1(operand1), .operand2(operand2),
    .kill(kill), .stall(stall_w[0]), .resp_valid(rv_w[0]), .result(res_w[0]));
  muldiv_unit #(.XLEN(32), .MUL_UNROLL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .operand1(operand1), .operand2(operand2),
    .kill(kill), .stall(stall_w[1]), .resp_valid(rv_w[1]), .result(res_w[1]));
  muldiv_unit #(.XLEN(32), .MUL_UNROLL(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .op(op), .operand1(operand1), .operand2(operand2),
    .kill(kill), .stall(stall_w[2]), .resp_valid(rv_w[2]), .result(res_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic plus the RISC-V corner-case rules.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    logic [63:0] p;
    logic [31:0] r;
    p = '0;
    case (o)
      3'd0: begin p = 64'(ua * ub); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
      3'd4: if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = 32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
            else r = 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int u);
    bit signed_div = (o == 3'd4) || (o == 3'd6);
    if (o[2] && (b == 0 || (signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    if (o[2]) return 33;
    return 32 / u + 1;
  endfunction

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %h, expected %h", tag, d, obs, exp);
    end
  endtask

  // Issue one request and check stall/resp_valid/result every cycle; abort_k >= 1 kills
  // (or resets) in that BUSY cycle, abort_k < 0 lets it run to completion.
  task automatic run_seq(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_in, input bit use_exp,
                         input int abort_k, input bit abort_rst);
    logic [31:0] exp_r;
    int lat [3];
    bit aborted;
    exp_r = use_exp ? exp_in : ref_res(o, a, b);
    for (int d = 0; d < 3; d++) lat[d] = latency(o, a, b, unroll[d]);
    for (int k = 0; k < 38; k++) begin
      start = (k == 0);
      if (k == 0) begin op = o; operand1 = a; operand2 = b; end
      kill = (k == abort_k) && !abort_rst;
      rst  = (k == abort_k) && abort_rst;
      #1;
      aborted = (abort_k >= 0) && (k > abort_k);
      for (int d = 0; d < 3; d++) begin
        if (aborted) begin
          check("stall_abort", d, 32'(stall_w[d]), 32'd0);
          check("valid_abort", d, 32'(rv_w[d]), 32'd0);
          check("result_abort", d, res_w[d], abort_rst ? 32'd0 : prev_res[d]);
        end else begin
          check("stall", d, 32'(stall_w[d]), 32'(k < lat[d]));
          check("valid", d, 32'(rv_w[d]), 32'(k == lat[d]));
          check("result", d, res_w[d], (k >= lat[d]) ? exp_r : prev_res[d]);
        end
      end
      @(negedge clk);
    end
    start = 1'b0; kill = 1'b0; rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      if (abort_k < 0) prev_res[d] = exp_r;
      else if (abort_rst) prev_res[d] = 32'd0;
    end
  endtask

  logic [2:0]  r_op;
  logic [31:0] r_a, r_b;
  int          sel;

  initial begin
    unroll[0] = 2; unroll[1] = 1; unroll[2] = 4;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0; operand1 = '0; operand2 = '0;
    for (int d = 0; d < 3; d++) prev_res[d] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check("reset_stall", d, 32'(stall_w[d]), 32'd0);
      check("reset_valid", d, 32'(rv_w[d]), 32'd0);
      check("reset_result", d, res_w[d], 32'd0);
    end
    @(negedge clk);

    // Directed vectors with hand-derived results.
    run_seq(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1, -1, 1'b0);
    run_seq(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b1, -1, 1'b0);
    run_seq(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1, 1'b0);
    run_seq(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, -1, 1'b0);
    run_seq(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b1, -1, 1'b0);
    run_seq(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b1, -1, 1'b0);
    run_seq(3'd5, 32'hFFFF_FFFF,  32'd16,        32'h0FFF_FFFF, 1'b1, -1, 1'b0);
    run_seq(3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1, -1, 1'b0);
    run_seq(3'd6, 32'd5,          32'd0,         32'd5,         1'b1, -1, 1'b0);
    run_seq(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, -1, 1'b0);
    run_seq(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1, -1, 1'b0);

    // Kill a DIV in its fifth BUSY cycle, then an ordinary MUL.
    run_seq(3'd4, 32'd1000,       32'd7,         32'd0,         1'b0, 5, 1'b0);
    run_seq(3'd0, 32'd3,          32'd4,         32'd12,        1'b1, -1, 1'b0);

    // Reset coinciding with a start request.
    rst = 1'b1; start = 1'b1; op = 3'd0; operand1 = 32'd9; operand2 = 32'd9;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      for (int d = 0; d < 3; d++) begin
        check("rst_start_stall", d, 32'(stall_w[d]), 32'd0);
        check("rst_start_valid", d, 32'(rv_w[d]), 32'd0);
        check("rst_start_result", d, res_w[d], 32'd0);
      end
      @(negedge clk);
    end
    for (int d = 0; d < 3; d++) prev_res[d] = '0;

    // Reset in the middle of a DIV after a non-zero result is on the port.
    run_seq(3'd0, 32'd123,        32'd456,       32'd56088,     1'b1, -1, 1'b0);
    run_seq(3'd4, 32'hFFFF_0000,  32'd3,         32'd0,         1'b0, 3, 1'b1);

    // Random operations against the reference model.
    for (int i = 0; i < 28; i++) begin
      r_op = 3'($urandom_range(7, 0));
      sel  = int'($urandom_range(5, 0));
      r_a  = $urandom;
      r_b  = $urandom;
      case (sel)
        0: r_b = 32'($urandom_range(15, 0));
        1: r_b = 32'd0;
        2: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        3: r_a = 32'($urandom_range(255, 0)) - 32'd128;
        default: ;
      endcase
      run_seq(r_op, r_a, r_b, 32'd0, 1'b0, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative RV32M multiply/divide unit, the successor to the separate multiplier/divider/controller trio. It sits beside the ALU in the Execute stage. It accepts one M-extension operation at a time, stalls the pipeline while iterating, and returns a single XLEN-bit result with a one-cycle valid pulse. It adds configurable multiply radix, divide-by-zero/overflow fast paths, signed high-half products, and pipeline kill.

## Interface
- XLEN, 32: operand/result width; even, ≥ 8.
- MUL_UNROLL, 2: multiplier bits retired per cycle; one of 1, 2, 4; must divide XLEN.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  funct3 of the M instruction: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- operand1  in  XLEN  rs1 value (forwarded SrcAE).
- operand2  in  XLEN  rs2 value (forwarded SrcBE).
- kill  in  1  flush of the Execute stage; aborts any operation.
- stall  out  1  combinational; high when (IDLE & start & !kill) or BUSY.
- resp_valid  out  1  registered; high for exactly one cycle in DONE.
- result  out  XLEN  registered; valid while resp_valid; holds last value otherwise.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE → BUSY on start & !kill: latch op, operand magnitudes, result sign, iteration counter.
- IDLE → DONE directly (fast path) for divide class when operand2 == 0, or signed DIV/REM with operand1 == 2^(XLEN-1) and operand2 == all-ones.
- BUSY → DONE when the counter reaches its final count; DONE → IDLE unconditionally.
- kill in BUSY or DONE → IDLE next cycle; resp_valid suppressed; no result update. kill in IDLE blocks acceptance.
- Multiply: unsigned shift-add on magnitudes, MUL_UNROLL bits per cycle, 2·XLEN accumulator. Final conditional two's-complement negation of the full 2·XLEN product.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - Signedness: MULH both signed; MULHSU op1 signed, op2 unsigned; MULHU/MUL neither (MUL's low half is sign-independent).
- Divide: restoring, 1 quotient bit per cycle on magnitudes.
  - Quotient negated if the operand signs differ (signed only); remainder takes the dividend's sign.
- Fast-path values:
  - Divide by zero: DIV/DIVU → all-ones; REM/REMU → operand1.
  - Signed overflow: DIV → 2^(XLEN-1); REM → 0.
- Magnitude of 2^(XLEN-1) is represented as unsigned XLEN bits without loss.

## Timing
- Start accepted at cycle T (IDLE, start high).
- Multiply: BUSY for XLEN/MUL_UNROLL cycles; resp_valid at T+XLEN/MUL_UNROLL+1. For XLEN=32, UNROLL=2 this is T+17.
- Divide: BUSY for XLEN cycles; resp_valid at T+XLEN+1. For XLEN=32 this is T+33.
- Fast path: resp_valid at T+1.
- stall is high from T through the last BUSY cycle and low in DONE, so the Execute register captures result on the DONE edge.
- A new start is not sampled in DONE. The earliest back-to-back start is the cycle after DONE.
- Reset values: state IDLE, resp_valid 0, result 0, counter 0, accumulators 0. stall 0 unless start is asserted.
- rst mid-operation has the same effect as kill and takes priority over kill and start.

## Structure
- muldiv_pkg holds:
  - muldiv_op_e (8 funct3 encodings) and muldiv_state_e {IDLE, BUSY, DONE}.
  - Helper functions is_div(op), op1_signed(op), op2_signed(op).
- One sub-module, mul_radix_step: combinational, consumes MUL_UNROLL multiplier bits and returns the updated 2·XLEN accumulator. It is instantiated once.
- The divider step is inline in muldiv_unit.

## Test plan
- MUL: 7 × −3 → result 0xFFFFFFEB at T+17 (UNROLL=2); stall high T..T+16, low at T+17.
- MULH: 0x80000000 × 0x80000000 → 0x40000000. MULHSU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU: same operands → 0xFFFFFFFE.
- DIV: −7 / 2 → 0xFFFFFFFD. REM: −7 % 2 → 0xFFFFFFFF. DIVU: 0xFFFFFFFF / 16 → 0x0FFFFFFF at T+33.
- Fast paths, each with resp_valid at T+1:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 % 0 → 5.
  - DIV 0x80000000 / −1 → 0x80000000.
  - REM 0x80000000 % −1 → 0.
- kill at T+5 of a DIV → IDLE at T+6, no resp_valid, result unchanged. A following MUL 3 × 4 → 12 at its own T+17.
- rst asserted together with start, and rst during BUSY → IDLE next cycle, resp_valid 0, result 0. Repeat all ops with MUL_UNROLL = 1 and 4, checking latencies of 33 and 9.
